// File: rtl/cr_su_hb_capture_pkg.sv
// Shared types and sizing for the SU debug history-buffer capture block.
package cr_su_hb_capture_pkg;
  localparam int CR_SU_HB_ENTRIES = 8;
  localparam int HB_ENTRY_W       = 108;
  localparam int HB_PTR_W         = $clog2(CR_SU_HB_ENTRIES);

  typedef logic [HB_ENTRY_W-1:0] hb_entry_t;

  typedef enum logic [1:0] {
    HB_IDLE      = 2'd0,
    HB_ARMED     = 2'd1,
    HB_POST_TRIG = 2'd2,
    HB_FROZEN    = 2'd3
  } hb_cap_state_e;
endpackage

// File: rtl/cr_su_hb_store.sv
// History storage: N_ENTRIES x ENTRY_W flops with one write port, all entries visible.
module cr_su_hb_store
  import cr_su_hb_capture_pkg::*;
#(
  parameter int N_ENTRIES = CR_SU_HB_ENTRIES,
  parameter int ENTRY_W   = HB_ENTRY_W,
  parameter int PTR_W     = HB_PTR_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [PTR_W-1:0]                 wptr,
  input  logic [ENTRY_W-1:0]               wdata,
  output logic [N_ENTRIES-1:0][ENTRY_W-1:0] entries
);
  logic [N_ENTRIES-1:0][ENTRY_W-1:0] entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (we) entry_d[wptr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign entries = entry_q;
endmodule

// File: rtl/cr_su_hb_capture.sv
// Capture sequencer: fills the circular history store while armed and freezes it
// a programmed number of events after a trigger.
module cr_su_hb_capture
  import cr_su_hb_capture_pkg::*;
#(
  parameter int N_ENTRIES = CR_SU_HB_ENTRIES,
  parameter int ENTRY_W   = HB_ENTRY_W,
  parameter int PTR_W     = HB_PTR_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_enable,
  input  logic [PTR_W-1:0]                  cfg_post_cnt,
  input  logic                              cfg_unfreeze,
  input  logic                              ev_valid,
  input  logic [ENTRY_W-1:0]                ev_data,
  input  logic                              ev_trigger,
  output logic [N_ENTRIES-1:0][ENTRY_W-1:0] su_hb,
  output logic [PTR_W-1:0]                  hb_wr_ptr,
  output logic                              hb_wrapped,
  output logic [1:0]                        hb_state,
  output logic                              hb_frozen,
  output logic                              su_agg_cnt_stb
);
  hb_cap_state_e    state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
  logic             wrapped_q, wrapped_d;
  logic             frozen_q, frozen_d;
  logic             stb_q, stb_d;
  logic             cap;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    post_cnt_d = post_cnt_q;
    wrapped_d  = wrapped_q;
    cap        = 1'b0;
    case (state_q)
      HB_IDLE: if (cfg_enable) state_d = HB_ARMED;
      HB_ARMED: begin
        if (!cfg_enable) state_d = HB_IDLE;
        else begin
          cap = ev_valid;
          if (ev_trigger) begin
            if (cfg_post_cnt == '0) state_d = HB_FROZEN;
            else begin
              state_d    = HB_POST_TRIG;
              post_cnt_d = cfg_post_cnt;
            end
          end
        end
      end
      HB_POST_TRIG: begin
        // post_cnt_q is never 0 here, so the 1->0 capture is the last one
        if (!cfg_enable) state_d = HB_IDLE;
        else if (ev_valid) begin
          cap        = 1'b1;
          post_cnt_d = post_cnt_q - PTR_W'(1);
          if (post_cnt_q == PTR_W'(1)) state_d = HB_FROZEN;
        end
      end
      HB_FROZEN: begin
        if (cfg_unfreeze) begin
          state_d   = cfg_enable ? HB_ARMED : HB_IDLE;
          wr_ptr_d  = '0;
          wrapped_d = 1'b0;
        end
      end
      default: state_d = HB_IDLE;
    endcase
    if (cap) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (wr_ptr_q == PTR_W'(N_ENTRIES-1)) wrapped_d = 1'b1;
    end
    frozen_d = (state_d == HB_FROZEN);
    stb_d    = cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HB_IDLE;
      wr_ptr_q   <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
      frozen_q   <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      post_cnt_q <= post_cnt_d;
      wrapped_q  <= wrapped_d;
      frozen_q   <= frozen_d;
      stb_q      <= stb_d;
    end
  end

  cr_su_hb_store #(
    .N_ENTRIES(N_ENTRIES),
    .ENTRY_W  (ENTRY_W),
    .PTR_W    (PTR_W)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cap),
    .wptr   (wr_ptr_q),
    .wdata  (ev_data),
    .entries(su_hb)
  );

  assign hb_wr_ptr      = wr_ptr_q;
  assign hb_wrapped     = wrapped_q;
  assign hb_state       = state_q;
  assign hb_frozen      = frozen_q;
  assign su_agg_cnt_stb = stb_q;
endmodule
